// File: rtl/hazard_ctrl.sv
// Stall/flush control for the RV32I 5-stage pipeline: load-use, branch flush,
// E-stage forwarding select and data-memory wait with a timeout FSM.
module hazard_ctrl #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned WAIT_W   = 5,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic             load_e,
   input  logic             reg_write_m,
   input  logic             reg_write_w,
   input  logic             pc_src_e,
   input  logic             dmem_req_m,
   input  logic             dmem_ready,
   input  logic             perf_clr,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              last, mem_wait, lw_stall, any_stall;

   always_comb begin
      forward_a_e = 2'b00;
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)
         forward_a_e = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e)
         forward_a_e = 2'b01;
   end

   always_comb begin
      forward_b_e = 2'b00;
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)
         forward_b_e = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e)
         forward_b_e = 2'b01;
   end

   assign lw_stall = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d)) && !pc_src_e;

   // last: final waiting cycle; the stall drops here so exactly MAX_WAIT-1 cycles are held
   assign last     = (state == WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT - 1)) && !dmem_ready;
   assign mem_wait = ((state == RUN) && dmem_req_m && !dmem_ready) ||
                     ((state == WAIT) && !dmem_ready && !last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN: begin
            if (dmem_req_m && !dmem_ready) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end
         end
         WAIT: begin
            if (dmem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (last) begin
               state_nxt    = ERR;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         ERR: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_m     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_w     = (state == ERR);
      mem_timeout = (state == ERR);
      if (mem_wait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (pc_src_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall && state != ERR) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   assign any_stall = stall_f | stall_d | stall_e | stall_m;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cycles <= '0;
      else if (perf_clr)
         stall_cycles <= '0;
      else if (any_stall && !(&stall_cycles))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default MAX_WAIT=16).
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic        load_e, reg_write_m, reg_write_w, pc_src_e;
   logic        dmem_req_m, dmem_ready, perf_clr;
   logic        stall_f, stall_d, stall_e, stall_m;
   logic        flush_d, flush_e, flush_w, mem_timeout;
   logic [1:0]  forward_a_e, forward_b_e;
   logic [31:0] stall_cycles;
   logic [6:0]  ctrl;

   int vectors = 0;
   int miscompares = 0;
   int exp_sc = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MAX_WAIT(16), .WAIT_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
      .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .pc_src_e(pc_src_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
      .perf_clr(perf_clr),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
   assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
      dmem_req_m = 0; dmem_ready = 0; perf_clr = 0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      vectors++;
      if (ctrl !== 7'b0000000) begin
         $display("FAIL reset_ctrl got %b want %b", ctrl, 7'b0000000); miscompares++;
      end
      vectors++;
      if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
         $display("FAIL reset_state got to=%b sc=%0d want to=0 sc=0", mem_timeout, stall_cycles);
         miscompares++;
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_forward;
      rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
      #1 vectors++;
      if (forward_a_e !== 2'b10) begin
         $display("FAIL fwd_a_m_beats_w got %b want 10", forward_a_e); miscompares++;
      end
      rd_m = 0;
      #1 vectors++;
      if (forward_a_e !== 2'b01) begin
         $display("FAIL fwd_a_w got %b want 01", forward_a_e); miscompares++;
      end
      rs2_e = 9; rd_m = 9; reg_write_w = 0;
      #1 vectors++;
      if (forward_b_e !== 2'b10 || forward_a_e !== 2'b00) begin
         $display("FAIL fwd_b_m got a=%b b=%b want a=00 b=10", forward_a_e, forward_b_e); miscompares++;
      end
      rs1_e = 0; rs2_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1; reg_write_w = 1;
      #1 vectors++;
      if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
         $display("FAIL fwd_x0 got a=%b b=%b want 00 00", forward_a_e, forward_b_e); miscompares++;
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_load_use;
      load_e = 1; rd_e = 7; rs2_d = 7;
      @(negedge clk) vectors++;
      if (ctrl !== 7'b1100010) begin
         $display("FAIL load_use got %b want 1100010", ctrl); miscompares++;
      end
      tick(); exp_sc++;
      pc_src_e = 1;
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000110) begin
         $display("FAIL load_use_branch got %b want 0000110", ctrl); miscompares++;
      end
      tick();
      clear_inputs();
      load_e = 1; rd_e = 0;
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000000) begin
         $display("FAIL load_x0 got %b want 0000000", ctrl); miscompares++;
      end
      vectors++;
      if (stall_cycles !== 32'(exp_sc)) begin
         $display("FAIL sc_after_flush got %0d want %0d", stall_cycles, exp_sc); miscompares++;
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_mem_wait;
      dmem_req_m = 1; dmem_ready = 0; pc_src_e = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) vectors++;
         if (ctrl !== 7'b1111001) begin
            $display("FAIL mem_wait_c%0d got %b want 1111001", i, ctrl); miscompares++;
         end
         tick(); exp_sc++;
      end
      dmem_ready = 1;
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000110) begin
         $display("FAIL mem_ready_release got %b want 0000110", ctrl); miscompares++;
      end
      tick();
      clear_inputs();
      @(negedge clk) vectors++;
      if (stall_cycles !== 32'(exp_sc)) begin
         $display("FAIL sc_mem_wait got %0d want %0d", stall_cycles, exp_sc); miscompares++;
      end
      tick();
   endtask

   task automatic test_timeout;
      dmem_req_m = 1; dmem_ready = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk) vectors++;
         if (ctrl !== 7'b1111001 || mem_timeout !== 1'b0) begin
            $display("FAIL timeout_wait_c%0d got %b to=%b want 1111001 to=0", i, ctrl, mem_timeout);
            miscompares++;
         end
         tick(); exp_sc++;
      end
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000000 || mem_timeout !== 1'b0) begin
         $display("FAIL timeout_last got %b to=%b want 0000000 to=0", ctrl, mem_timeout); miscompares++;
      end
      tick();
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000001 || mem_timeout !== 1'b1) begin
         $display("FAIL timeout_err got %b to=%b want 0000001 to=1", ctrl, mem_timeout); miscompares++;
      end
      tick();
      dmem_req_m = 0;
      @(negedge clk) vectors++;
      if (ctrl !== 7'b0000000 || mem_timeout !== 1'b0) begin
         $display("FAIL timeout_pulse_end got %b to=%b want 0000000 to=0", ctrl, mem_timeout); miscompares++;
      end
      vectors++;
      if (stall_cycles !== 32'(exp_sc)) begin
         $display("FAIL sc_timeout got %0d want %0d", stall_cycles, exp_sc); miscompares++;
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_perf_clr;
      load_e = 1; rd_e = 3; rs1_d = 3; perf_clr = 1;
      tick(); exp_sc = 0;
      @(negedge clk) vectors++;
      if (stall_cycles !== 32'(exp_sc)) begin
         $display("FAIL perf_clr_wins got %0d want %0d", stall_cycles, exp_sc); miscompares++;
      end
      perf_clr = 0;
      tick(); exp_sc++;
      clear_inputs();
      @(negedge clk) vectors++;
      if (stall_cycles !== 32'(exp_sc)) begin
         $display("FAIL perf_after_clr got %0d want %0d", stall_cycles, exp_sc); miscompares++;
      end
      tick();
   endtask

   task automatic test_reset_mid_wait;
      dmem_req_m = 1; dmem_ready = 0;
      tick(); tick();
      @(negedge clk);
      reset_n = 0; dmem_req_m = 0;
      #1 vectors++;
      if (ctrl !== 7'b0000000 || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
         $display("FAIL reset_mid_wait got %b to=%b sc=%0d want 0000000 to=0 sc=0",
                  ctrl, mem_timeout, stall_cycles);
         miscompares++;
      end
      dmem_req_m = 1;
      #1 vectors++;
      if (ctrl !== 7'b1111001) begin
         $display("FAIL reset_run_follow got %b want 1111001", ctrl); miscompares++;
      end
      dmem_req_m = 0;
      @(negedge clk) reset_n = 1;
      tick();
      @(negedge clk) vectors++;
      if (stall_cycles !== 32'd0 || ctrl !== 7'b0000000) begin
         $display("FAIL post_reset got %b sc=%0d want 0000000 sc=0", ctrl, stall_cycles); miscompares++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      test_reset();
      test_forward();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_perf_clr();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
